shot_ctl: RTL and testbench

Shot evaluation and hit bookkeeping for the game controller. Detects mouse left-click rising edges, snapshots the cursor and the duck position from `duck_ctl`, and decides hit or miss against the duck bounding box. It drives `target_killed` and `new_duck` back to the duck motion logic, plus `shots_left` and `hit_count` to the HUD. It sits between the mouse interface and `duck_ctl` in the game-control layer, on the `clk` domain.

---
 rtl/game_pkg.sv | 17 +
 rtl/rise_edge.sv | 18 +
 rtl/shot_ctl.sv | 116 +++++++++++
 tb/tb_shot_ctl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game constants and shot controller state type
package game_pkg;

  localparam int DUCK_WIDTH  = 96;
  localparam int DUCK_HEIGHT = 32;
  localparam int X_MAX       = 1024;
  localparam int GROUND      = 620;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CHECK,
    S_HIT_HOLD,
    S_ESCAPE
  } shot_state_t;

endpackage

// File: rtl/rise_edge.sv
// rtl/rise_edge.sv - rising-edge detector against the previous registered sample
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/shot_ctl.sv
// rtl/shot_ctl.sv - click evaluation against the duck box, hold phases and hit bookkeeping
module shot_ctl #(
  parameter int DUCK_WIDTH  = game_pkg::DUCK_WIDTH,
  parameter int DUCK_HEIGHT = game_pkg::DUCK_HEIGHT,
  parameter int SHOTS       = 3,
  parameter int HOLD_CYCLES = 65_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_enable,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic [11:0] duck_xpos,
  input  logic [11:0] duck_ypos,
  output logic        target_killed,
  output logic        duck_escaped,
  output logic        new_duck,
  output logic [1:0]  shots_left,
  output logic [7:0]  hit_count
);
  import game_pkg::*;

  localparam int          CW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [1:0]  SHOTS_INIT = 2'(SHOTS);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  shot_state_t   state;
  logic [CW-1:0] hold_cnt;
  logic [11:0]   mx, my, dx, dy;
  logic          click;
  logic          hit;

  rise_edge u_click (
    .clk  (clk),
    .rst  (rst),
    .d    (mouse_left),
    .rise (click)
  );

  // 13-bit sums keep ducks near the right/bottom limit from wrapping
  assign hit = ({1'b0, mx} >= {1'b0, dx}) &&
               ({1'b0, mx} <  {1'b0, dx} + 13'(DUCK_WIDTH)) &&
               ({1'b0, my} >= {1'b0, dy}) &&
               ({1'b0, my} <  {1'b0, dy} + 13'(DUCK_HEIGHT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      hold_cnt      <= '0;
      mx            <= '0;
      my            <= '0;
      dx            <= '0;
      dy            <= '0;
      target_killed <= 1'b0;
      duck_escaped  <= 1'b0;
      new_duck      <= 1'b0;
      shots_left    <= SHOTS_INIT;
      hit_count     <= '0;
    end else begin
      new_duck <= 1'b0;
      if (!game_enable) begin
        state         <= S_IDLE;
        hold_cnt      <= '0;
        target_killed <= 1'b0;
        duck_escaped  <= 1'b0;
        shots_left    <= SHOTS_INIT;
      end else begin
        case (state)
          S_IDLE: begin
            shots_left <= SHOTS_INIT;
            hold_cnt   <= '0;
            state      <= S_ARMED;
          end
          S_ARMED: begin
            if (click) begin
              mx    <= mouse_xpos;
              my    <= mouse_ypos;
              dx    <= duck_xpos;
              dy    <= duck_ypos;
              state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (hit) begin
              target_killed <= 1'b1;
              if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
              state <= S_HIT_HOLD;
            end else if (shots_left > 2'd1) begin
              shots_left <= shots_left - 2'd1;
              state      <= S_ARMED;
            end else begin
              shots_left   <= 2'd0;
              duck_escaped <= 1'b1;
              state        <= S_ESCAPE;
            end
          end
          S_HIT_HOLD, S_ESCAPE: begin
            if (hold_cnt == HOLD_LAST) begin
              target_killed <= 1'b0;
              duck_escaped  <= 1'b0;
              new_duck      <= 1'b1;
              shots_left    <= SHOTS_INIT;
              hold_cnt      <= '0;
              state         <= S_ARMED;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shot_ctl.sv
// tb/tb_shot_ctl.sv - directed and randomized checks of shot_ctl against a box/counter model
module tb_shot_ctl;

  localparam int HOLD  = 8;
  localparam int NSHOT = 3;
  localparam int DW    = 96;
  localparam int DH    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_enable = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic [11:0] duck_xpos = '0;
  logic [11:0] duck_ypos = '0;
  logic        target_killed;
  logic        duck_escaped;
  logic        new_duck;
  logic [1:0]  shots_left;
  logic [7:0]  hit_count;

  int compared = 0;
  int mismatched = 0;
  int exp_hits = 0;
  int exp_shots = NSHOT;

  shot_ctl #(
    .DUCK_WIDTH  (DW),
    .DUCK_HEIGHT (DH),
    .SHOTS       (NSHOT),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .game_enable   (game_enable),
    .mouse_left    (mouse_left),
    .mouse_xpos    (mouse_xpos),
    .mouse_ypos    (mouse_ypos),
    .duck_xpos     (duck_xpos),
    .duck_ypos     (duck_ypos),
    .target_killed (target_killed),
    .duck_escaped  (duck_escaped),
    .new_duck      (new_duck),
    .shots_left    (shots_left),
    .hit_count     (hit_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_box(input int mx, input int my, input int dx, input int dy);
    return (mx >= dx) && (mx < dx + DW) && (my >= dy) && (my < dy + DH);
  endfunction

  // One click from ARMED; optionally pokes the button during the hold phase
  task automatic shoot(input int mx, input int my, input int dx, input int dy, input bit poke);
    bit exp_hit;
    bit hold;
    exp_hit = in_box(mx, my, dx, dy);
    mouse_xpos = 12'(mx); mouse_ypos = 12'(my);
    duck_xpos  = 12'(dx); duck_ypos  = 12'(dy);
    mouse_left = 1'b1;
    tick();
    duck_xpos  = 12'($urandom_range(0, 4095));
    duck_ypos  = 12'($urandom_range(0, 4095));
    mouse_xpos = 12'($urandom_range(0, 4095));
    mouse_left = 1'b0;
    tick();
    hold = 1'b1;
    if (exp_hit) begin
      if (exp_hits < 255) exp_hits++;
    end else if (exp_shots > 1) begin
      exp_shots--;
      hold = 1'b0;
    end else begin
      exp_shots = 0;
    end
    check("killed", int'(target_killed), int'(exp_hit));
    check("escaped", int'(duck_escaped), int'(hold && !exp_hit));
    check("shots", int'(shots_left), exp_shots);
    check("hits", int'(hit_count), exp_hits);
    if (hold) begin
      for (int i = 1; i < HOLD; i++) begin
        mouse_xpos = 12'(dx + 1); mouse_ypos = 12'(dy + 1);
        mouse_left = (poke && i < HOLD - 2) ? i[0] : 1'b0;
        tick();
        check("hold_flag", int'(target_killed | duck_escaped), 1);
      end
      mouse_left = 1'b0;
      tick();
      exp_shots = NSHOT;
      check("new_duck", int'(new_duck), 1);
      check("hold_end", int'(target_killed | duck_escaped), 0);
      check("reload", int'(shots_left), exp_shots);
      check("hits_after_hold", int'(hit_count), exp_hits);
      tick();
      check("new_duck_pulse", int'(new_duck), 0);
    end
  endtask

  initial begin
    int dx, dy, mx, my;
    tick(); tick();
    check("rst_killed", int'(target_killed), 0);
    check("rst_escaped", int'(duck_escaped), 0);
    check("rst_new_duck", int'(new_duck), 0);
    check("rst_shots", int'(shots_left), NSHOT);
    check("rst_hits", int'(hit_count), 0);
    rst = 1'b0;
    game_enable = 1'b1;
    tick();

    shoot(150, 210, 100, 200, 1'b0);
    shoot(195, 231, 100, 200, 1'b0);
    shoot(196, 231, 100, 200, 1'b0);
    shoot(100, 232, 100, 200, 1'b0);
    shoot(99, 200, 100, 200, 1'b0);
    shoot(900, 10, 100, 200, 1'b0);
    shoot(900, 10, 100, 200, 1'b0);
    shoot(900, 10, 100, 200, 1'b0);
    shoot(4095, 4095, 4090, 4090, 1'b0);
    shoot(10, 10, 4050, 4090, 1'b0);

    // held button: only the first edge counts
    mouse_xpos = 12'd900; mouse_ypos = 12'd10;
    duck_xpos = 12'd100;  duck_ypos = 12'd200;
    mouse_left = 1'b1;
    repeat (50) tick();
    mouse_left = 1'b0;
    tick();
    exp_shots--;
    check("held_shots", int'(shots_left), exp_shots);
    check("held_escaped", int'(duck_escaped), 0);
    shoot(120, 220, 100, 200, 1'b1);

    // enable dropped mid-hold
    mouse_xpos = 12'd150; mouse_ypos = 12'd210;
    duck_xpos = 12'd100;  duck_ypos = 12'd200;
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    tick();
    exp_hits++;
    check("drop_killed_on", int'(target_killed), 1);
    tick(); tick();
    game_enable = 1'b0;
    tick();
    check("drop_killed", int'(target_killed), 0);
    check("drop_new_duck", int'(new_duck), 0);
    check("drop_hits", int'(hit_count), exp_hits);
    repeat (10) begin
      tick();
      check("idle_new_duck", int'(new_duck), 0);
    end
    game_enable = 1'b1;
    tick();
    exp_shots = NSHOT;
    check("reenable_shots", int'(shots_left), exp_shots);

    for (int n = 0; n < 24; n++) begin
      dx = int'($urandom_range(0, 4095));
      dy = int'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) begin
        mx = (dx + int'($urandom_range(0, DW - 1))) & 4095;
        my = (dy + int'($urandom_range(0, DH - 1))) & 4095;
      end else begin
        mx = int'($urandom_range(0, 4095));
        my = int'($urandom_range(0, 4095));
      end
      shoot(mx, my, dx, dy, 1'($urandom_range(0, 1)));
    end

    for (int n = 0; n < 256; n++) shoot(300, 300, 250, 290, 1'b0);
    check("saturated", int'(hit_count), 255);

    // reset while escaping
    shoot(900, 10, 100, 200, 1'b0);
    shoot(900, 10, 100, 200, 1'b0);
    mouse_left = 1'b1;
    tick();
    mouse_left = 1'b0;
    tick();
    check("esc_on", int'(duck_escaped), 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("rst2_killed", int'(target_killed), 0);
    check("rst2_escaped", int'(duck_escaped), 0);
    check("rst2_new_duck", int'(new_duck), 0);
    check("rst2_shots", int'(shots_left), NSHOT);
    check("rst2_hits", int'(hit_count), 0);
    rst = 1'b0;
    exp_hits = 0;
    exp_shots = NSHOT;
    tick();
    shoot(101, 201, 100, 200, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
